mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder_pkg.sv | 34 +++
 rtl/mmio_responder_if.sv | 40 ++++
 rtl/mmio_responder_parity.sv | 15 +
 rtl/mmio_responder.sv | 194 +++++++++++++++++++
 tb/tb_mmio_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: the register map, the FSM state
// type and the request record captured when a host access is accepted.
package mmio_responder_pkg;

    // Host-visible register word addresses. Bit 0 selects the 32-bit half.
    localparam logic [23:0] ALGO_REQUEST_ADDR = 24'hFFFFFC;
    localparam logic [23:0] ALGO_STATUS_ADDR  = 24'hFFFFFE;
    localparam logic [23:0] ERROR_REG_ADDR    = 24'hFFFFFA;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } mmio_state_t;

    // Register selected by the captured address.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_REQUEST,
        SEL_STATUS,
        SEL_ERROR
    } mmio_sel_t;

    // Accepted access in decoded form. The address is kept as the register
    // select plus the half-select bit. Write data is applied on the accept
    // edge, so it does not need to be held.
    typedef struct packed {
        logic      read;
        logic      dw;
        logic      odd;
        mmio_sel_t sel;
    } mmio_req_t;

endpackage

// File: rtl/mmio_responder_if.sv
// Host-side MMIO bus of the responder. The parity signals exist only when
// MMIO_PARITY_EN is defined.
interface mmio_responder_if #(
    parameter int MMIO_ADDR_BITS = 24,
    parameter int MMIO_DATA_BITS = 64
);
    logic                      mmio_valid;
    logic                      mmio_read;
    logic                      mmio_dw;
    logic [MMIO_ADDR_BITS-1:0] mmio_address;
    logic [MMIO_DATA_BITS-1:0] mmio_wdata;
    logic                      mmio_ack;
    logic [MMIO_DATA_BITS-1:0] mmio_rdata;
`ifdef MMIO_PARITY_EN
    logic                      mmio_wdata_parity;
    logic                      mmio_rdata_parity;

    modport master (
        output mmio_valid, mmio_read, mmio_dw, mmio_address, mmio_wdata,
        output mmio_wdata_parity,
        input  mmio_ack, mmio_rdata, mmio_rdata_parity
    );

    modport slave (
        input  mmio_valid, mmio_read, mmio_dw, mmio_address, mmio_wdata,
        input  mmio_wdata_parity,
        output mmio_ack, mmio_rdata, mmio_rdata_parity
    );
`else
    modport master (
        output mmio_valid, mmio_read, mmio_dw, mmio_address, mmio_wdata,
        input  mmio_ack, mmio_rdata
    );

    modport slave (
        input  mmio_valid, mmio_read, mmio_dw, mmio_address, mmio_wdata,
        output mmio_ack, mmio_rdata
    );
`endif
endinterface

// File: rtl/mmio_responder_parity.sv
// Parity helper for the MMIO responder (used only with MMIO_PARITY_EN).
// Odd parity: a data word together with its parity bit holds an odd number
// of ones.
module mmio_parity #(
    parameter int DATA_BITS = 64
) (
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 wdata_parity,
    input  logic [DATA_BITS-1:0] rdata,
    output logic                 wdata_ok,
    output logic                 rdata_parity
);
    assign wdata_ok     = ^{wdata, wdata_parity};
    assign rdata_parity = ~^rdata;
endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: a three-register slave with a fixed two-cycle response.
// The host strobes mmio_valid. The access is acknowledged two cycles later,
// with one cycle in ACCESS and one in ACK.
// Optional build macro: MMIO_PARITY_EN adds write-data parity checking and
// read-data parity generation through mmio_parity.
// Error bits use MSB-first numbering, so error bit 0 is the top bit of the word.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int MMIO_ADDR_BITS = 24,
    parameter int MMIO_DATA_BITS = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    mmio_responder_if.slave           mmio,
    input  logic [MMIO_DATA_BITS-1:0] algo_status_in,
    input  logic                      algo_status_valid,
    input  logic [MMIO_DATA_BITS-1:0] error_in,
    output logic [MMIO_DATA_BITS-1:0] algo_request_out,
    output logic                      algo_request_valid
);

    localparam int HALF        = MMIO_DATA_BITS / 2;
    localparam int OVERLAP_BIT = MMIO_DATA_BITS - 1;  // error bit 0
    localparam int PARITY_BIT  = MMIO_DATA_BITS - 2;  // error bit 1

    localparam logic [MMIO_ADDR_BITS-1:0] REQUEST_A = MMIO_ADDR_BITS'(ALGO_REQUEST_ADDR);
    localparam logic [MMIO_ADDR_BITS-1:0] STATUS_A  = MMIO_ADDR_BITS'(ALGO_STATUS_ADDR);
    localparam logic [MMIO_ADDR_BITS-1:0] ERROR_A   = MMIO_ADDR_BITS'(ERROR_REG_ADDR);

    // Register decode ignores bit 0. For 32-bit accesses that bit is the half select.
    function automatic mmio_sel_t decode(input logic [MMIO_ADDR_BITS-1:0] addr);
        mmio_sel_t sel;
        sel = SEL_NONE;
        if (addr[MMIO_ADDR_BITS-1:1] == REQUEST_A[MMIO_ADDR_BITS-1:1]) sel = SEL_REQUEST;
        if (addr[MMIO_ADDR_BITS-1:1] == STATUS_A[MMIO_ADDR_BITS-1:1])  sel = SEL_STATUS;
        if (addr[MMIO_ADDR_BITS-1:1] == ERROR_A[MMIO_ADDR_BITS-1:1])   sel = SEL_ERROR;
        return sel;
    endfunction

    // An even address selects the upper half (bits 0..31, MSB-first).
    // An odd address selects the lower half. Writes take the matching data lane.
    function automatic logic [MMIO_DATA_BITS-1:0] merge_write(
        input logic [MMIO_DATA_BITS-1:0] cur,
        input logic [MMIO_DATA_BITS-1:0] wdata,
        input logic                      dw,
        input logic                      odd
    );
        logic [MMIO_DATA_BITS-1:0] res;
        res = cur;
        if (dw)
            res = wdata;
        else if (odd)
            res[HALF-1:0] = wdata[HALF-1:0];
        else
            res[MMIO_DATA_BITS-1:HALF] = wdata[MMIO_DATA_BITS-1:HALF];
        return res;
    endfunction

    // A 32-bit read replicates the selected half in both lanes.
    function automatic logic [MMIO_DATA_BITS-1:0] read_view(
        input logic [MMIO_DATA_BITS-1:0] value,
        input logic                      dw,
        input logic                      odd
    );
        if (dw)
            return value;
        else if (odd)
            return {value[HALF-1:0], value[HALF-1:0]};
        else
            return {value[MMIO_DATA_BITS-1:HALF], value[MMIO_DATA_BITS-1:HALF]};
    endfunction

    mmio_state_t               state;
    mmio_req_t                 req_q;
    logic                      ack_q;
    logic [MMIO_DATA_BITS-1:0] rdata_q;
    logic                      request_valid_q;
    logic [MMIO_DATA_BITS-1:0] request_q;
    logic [MMIO_DATA_BITS-1:0] status_q;
    logic [MMIO_DATA_BITS-1:0] error_q;

    logic                      wdata_ok;
    logic                      capture;
    logic                      overlap;
    mmio_sel_t                 in_sel;
    logic                      request_write;
    logic [MMIO_DATA_BITS-1:0] error_next;
    logic [MMIO_DATA_BITS-1:0] read_value;

`ifdef MMIO_PARITY_EN
    logic rdata_parity;

    mmio_parity #(
        .DATA_BITS(MMIO_DATA_BITS)
    ) u_parity (
        .wdata        (mmio.mmio_wdata),
        .wdata_parity (mmio.mmio_wdata_parity),
        .rdata        (rdata_q),
        .wdata_ok     (wdata_ok),
        .rdata_parity (rdata_parity)
    );

    assign mmio.mmio_rdata_parity = rdata_parity;
`else
    assign wdata_ok = 1'b1;
`endif

    assign capture = (state == IDLE) && mmio.mmio_valid;
    assign overlap = (state != IDLE) && mmio.mmio_valid;
    assign in_sel  = decode(mmio.mmio_address);

    // ALGO_REQUEST is written on the accept edge.
    // The new value and the pulse are then both visible during ACCESS.
    assign request_write = capture && !mmio.mmio_read && (in_sel == SEL_REQUEST) && wdata_ok;

    // Sticky error accumulation. A host read of ERROR_REG clears it but keeps
    // sources that fire in that same cycle.
    always_comb begin
        logic [MMIO_DATA_BITS-1:0] flags;
        flags              = '0;
        flags[OVERLAP_BIT] = overlap;
        flags[PARITY_BIT]  = capture && !mmio.mmio_read && !wdata_ok;
        if ((state == ACCESS) && req_q.read && (req_q.sel == SEL_ERROR))
            error_next = error_in | flags;
        else
            error_next = error_q | error_in | flags;
    end

    // Read data comes from the register values held during ACCESS, before any update on that edge.
    always_comb begin
        logic [MMIO_DATA_BITS-1:0] sel_value;
        case (req_q.sel)
            SEL_REQUEST: sel_value = request_q;
            SEL_STATUS:  sel_value = status_q;
            SEL_ERROR:   sel_value = error_q;
            default:     sel_value = '0;
        endcase
        read_value = req_q.read ? read_view(sel_value, req_q.dw, req_q.odd) : '0;
    end

    // Capture the accepted request. This is data only, so it has no reset.
    always_ff @(posedge clock) begin
        if (capture)
            req_q <= '{read: mmio.mmio_read, dw: mmio.mmio_dw,
                       odd: mmio.mmio_address[0], sel: in_sel};
    end

    // Handshake FSM and register file. Reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ack_q           <= 1'b0;
            rdata_q         <= '0;
            request_valid_q <= 1'b0;
            request_q       <= '0;
            status_q        <= '0;
            error_q         <= '0;
        end else begin
            request_valid_q <= request_write;
            if (request_write)
                request_q <= merge_write(request_q, mmio.mmio_wdata, mmio.mmio_dw,
                                         mmio.mmio_address[0]);
            if (algo_status_valid)
                status_q <= algo_status_in;
            error_q <= error_next;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            case (state)
                IDLE: begin
                    if (mmio.mmio_valid)
                        state <= ACCESS;
                end
                ACCESS: begin
                    ack_q   <= 1'b1;
                    rdata_q <= read_value;
                    state   <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mmio.mmio_ack      = ack_q;
    assign mmio.mmio_rdata    = rdata_q;
    assign algo_request_out   = request_q;
    assign algo_request_valid = request_valid_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Testbench for mmio_responder. A table of register accesses runs first.
// Hand-written sequences follow for status timing, sticky errors, overlapping
// strobes and reset abort. Expected read data goes into a scoreboard queue and
// is popped whenever the DUT acknowledges.
module tb_mmio_responder;
    import mmio_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] algo_status_in;
    logic        algo_status_valid;
    logic [63:0] error_in;
    logic [63:0] algo_request_out;
    logic        algo_request_valid;

    mmio_responder_if bus ();

    mmio_responder dut (
        .clock              (clock),
        .reset              (reset),
        .mmio               (bus),
        .algo_status_in     (algo_status_in),
        .algo_status_valid  (algo_status_valid),
        .error_in           (error_in),
        .algo_request_out   (algo_request_out),
        .algo_request_valid (algo_request_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        chk;
        logic [63:0] val;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        dw;
        logic [23:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_rv;
        logic [63:0] exp_req;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[14];

    localparam logic [63:0] ERR_BIT0 = 64'h8000_0000_0000_0000;  // MSB-first bit 0
    localparam logic [63:0] ERR_BIT5 = 64'h0400_0000_0000_0000;  // MSB-first bit 5

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic dw, input logic [23:0] addr,
                         input logic [63:0] wdata);
        bus.mmio_valid   = 1'b1;
        bus.mmio_read    = rd;
        bus.mmio_dw      = dw;
        bus.mmio_address = addr;
        bus.mmio_wdata   = wdata;
`ifdef MMIO_PARITY_EN
        bus.mmio_wdata_parity = ~^wdata;
`endif
    endtask

    // One full access with the latency checked: valid at t, ack only at t+2.
    task automatic access(input logic rd, input logic dw, input logic [23:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rdata,
                          input logic exp_rv, input string name);
        drive(rd, dw, addr, wdata);
        exp_q.push_back('{rd, exp_rdata});
        tick();
        bus.mmio_valid = 1'b0;
        check64({name, "_rv"}, {63'b0, algo_request_valid}, {63'b0, exp_rv});
        check64({name, "_ack_t1"}, {63'b0, bus.mmio_ack}, 64'd0);
        tick();
        check64({name, "_ack_t2"}, {63'b0, bus.mmio_ack}, 64'd1);
        tick();
        check64({name, "_ack_t3"}, {63'b0, bus.mmio_ack}, 64'd0);
    endtask

    // Scoreboard side: every ack pops one expectation, and rdata must be 0 whenever ack is low.
    always @(negedge clock) begin
        exp_t e;
        if (mon_on) begin
            if (bus.mmio_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with rdata %h expected no ack", bus.mmio_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk)
                        check64("ack_rdata", bus.mmio_rdata, e.val);
                end
            end else begin
                check64("idle_rdata", bus.mmio_rdata, 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 24'hFFFFFC, 64'hDEADBEEF_00000001, 64'h0, 1'b1, 64'hDEADBEEF_00000001};
        vecs[1]  = '{1'b1, 1'b1, 24'hFFFFFC, 64'h0, 64'hDEADBEEF_00000001, 1'b0, 64'hDEADBEEF_00000001};
        vecs[2]  = '{1'b1, 1'b1, 24'hFFFFFD, 64'h0, 64'hDEADBEEF_00000001, 1'b0, 64'hDEADBEEF_00000001};
        vecs[3]  = '{1'b0, 1'b0, 24'hFFFFFC, 64'h11112222_11112222, 64'h0, 1'b1, 64'h11112222_00000001};
        vecs[4]  = '{1'b0, 1'b0, 24'hFFFFFD, 64'h33334444_33334444, 64'h0, 1'b1, 64'h11112222_33334444};
        vecs[5]  = '{1'b1, 1'b0, 24'hFFFFFD, 64'h0, 64'h33334444_33334444, 1'b0, 64'h11112222_33334444};
        vecs[6]  = '{1'b1, 1'b0, 24'hFFFFFC, 64'h0, 64'h11112222_11112222, 1'b0, 64'h11112222_33334444};
        vecs[7]  = '{1'b0, 1'b1, 24'hFFFFFE, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[8]  = '{1'b1, 1'b1, 24'hFFFFFE, 64'h0, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[9]  = '{1'b1, 1'b1, 24'h000010, 64'h0, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[10] = '{1'b0, 1'b1, 24'h000010, 64'hCAFEF00D_CAFEF00D, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[11] = '{1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[12] = '{1'b0, 1'b1, 24'hFFFFFA, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0, 64'h11112222_33334444};
        vecs[13] = '{1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h0, 1'b0, 64'h11112222_33334444};

        reset             = 1'b1;
        bus.mmio_valid    = 1'b0;
        bus.mmio_read     = 1'b0;
        bus.mmio_dw       = 1'b0;
        bus.mmio_address  = '0;
        bus.mmio_wdata    = '0;
`ifdef MMIO_PARITY_EN
        bus.mmio_wdata_parity = 1'b1;
`endif
        algo_status_in    = '0;
        algo_status_valid = 1'b0;
        error_in          = '0;
        repeat (3) tick();

        check64("reset_ack", {63'b0, bus.mmio_ack}, 64'd0);
        check64("reset_rdata", bus.mmio_rdata, 64'd0);
        check64("reset_rv", {63'b0, algo_request_valid}, 64'd0);
        check64("reset_req_out", algo_request_out, 64'd0);
        reset  = 1'b0;
        mon_on = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].rd, vecs[i].dw, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_rv, $sformatf("vec%0d", i));
            check64($sformatf("vec%0d_req_out", i), algo_request_out, vecs[i].exp_req);
        end

        // Status load, then readback.
        algo_status_in    = 64'h1;
        algo_status_valid = 1'b1;
        tick();
        algo_status_valid = 1'b0;
        access(1'b1, 1'b1, 24'hFFFFFE, 64'h0, 64'h1, 1'b0, "status_read");

        // A status update during ACCESS is not visible to that read.
        drive(1'b1, 1'b1, 24'hFFFFFE, 64'h0);
        exp_q.push_back('{1'b1, 64'h1});
        tick();
        bus.mmio_valid    = 1'b0;
        algo_status_in    = 64'h2;
        algo_status_valid = 1'b1;
        tick();
        algo_status_valid = 1'b0;
        check64("status_race_ack", {63'b0, bus.mmio_ack}, 64'd1);
        tick();
        access(1'b1, 1'b0, 24'hFFFFFF, 64'h0, 64'h00000002_00000002, 1'b0, "status_half_read");
        access(1'b1, 1'b1, 24'hFFFFFE, 64'h0, 64'h2, 1'b0, "status_new_read");

        // Sticky error bit 5, cleared by the first read.
        error_in = ERR_BIT5;
        tick();
        error_in = '0;
        tick();
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, ERR_BIT5, 1'b0, "err5_read1");
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h0, 1'b0, "err5_read2");

        // An error source that fires during the clearing read is retained.
        drive(1'b1, 1'b1, 24'hFFFFFA, 64'h0);
        exp_q.push_back('{1'b1, 64'h0});
        tick();
        bus.mmio_valid = 1'b0;
        error_in       = 64'h100;
        tick();
        error_in = '0;
        check64("err_keep_ack", {63'b0, bus.mmio_ack}, 64'd1);
        tick();
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h100, 1'b0, "err_keep_read");
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h0, 1'b0, "err_keep_clear");

        // A second strobe at t+1 is ignored and flags error bit 0.
        drive(1'b1, 1'b1, 24'h000010, 64'h0);
        exp_q.push_back('{1'b1, 64'h0});
        tick();
        drive(1'b0, 1'b1, 24'hFFFFFC, 64'hBADBADBA_DBADBADB);
        check64("overlap_ack_t1", {63'b0, bus.mmio_ack}, 64'd0);
        tick();
        bus.mmio_valid = 1'b0;
        check64("overlap_ack_t2", {63'b0, bus.mmio_ack}, 64'd1);
        check64("overlap_rv", {63'b0, algo_request_valid}, 64'd0);
        tick();
        check64("overlap_ack_t3", {63'b0, bus.mmio_ack}, 64'd0);
        tick();
        check64("overlap_no_second_ack", {63'b0, bus.mmio_ack}, 64'd0);
        check64("overlap_req_out", algo_request_out, 64'h11112222_33334444);
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, ERR_BIT0, 1'b0, "overlap_err_read");
        access(1'b1, 1'b1, 24'hFFFFFA, 64'h0, 64'h0, 1'b0, "overlap_err_clear");

        // Reset during ACCESS aborts the access and clears every register.
        drive(1'b1, 1'b1, 24'hFFFFFC, 64'h0);
        tick();
        bus.mmio_valid = 1'b0;
        reset          = 1'b1;
        tick();
        reset = 1'b0;
        check64("abort_ack", {63'b0, bus.mmio_ack}, 64'd0);
        check64("abort_rdata", bus.mmio_rdata, 64'd0);
        check64("abort_rv", {63'b0, algo_request_valid}, 64'd0);
        check64("abort_req_out", algo_request_out, 64'd0);
        tick();
        check64("abort_ack_later", {63'b0, bus.mmio_ack}, 64'd0);
        access(1'b1, 1'b1, 24'hFFFFFC, 64'h0, 64'h0, 1'b0, "abort_req_read");
        access(1'b1, 1'b1, 24'hFFFFFE, 64'h0, 64'h0, 1'b0, "abort_status_read");

        tick();
        check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
